pipe_addsub: RTL

- Parametrised, pipelined add/subtract unit; successor to the datapath's single-cycle 32-bit adder.
- Splits the WIDTH-bit operation into STAGES equal slices, one slice per cycle, with the carry registered between stages.
- Uses valid/ready handshakes at input and output.
- Reports carry, signed overflow and zero flags.
- Used where a wide add would otherwise limit clock frequency (branch target, address generation, multi-cycle ALU).

---
 rtl/pipe_addsub_if.sv | 39 +++
 rtl/pipe_addsub.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub. The sat_in signal exists
// only when PIPE_ADDSUB_SAT_EN is defined.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] data1_in;
  logic [WIDTH-1:0] data2_in;
  logic             sub_in;
  logic             carry_in;
`ifdef PIPE_ADDSUB_SAT_EN
  logic             sat_in;
`endif
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
  logic             overflow_out;
  logic             zero_out;

  // The unit's own view: operands and downstream ready come in, results go out.
  modport slave (
    input  valid_in, data1_in, data2_in, sub_in, carry_in, ready_in,
`ifdef PIPE_ADDSUB_SAT_EN
    input  sat_in,
`endif
    output ready_out, valid_out, data_out, carry_out, overflow_out, zero_out
  );

  // The environment's view: drives operands, consumes results.
  modport master (
    output valid_in, data1_in, data2_in, sub_in, carry_in, ready_in,
`ifdef PIPE_ADDSUB_SAT_EN
    output sat_in,
`endif
    input  ready_out, valid_out, data_out, carry_out, overflow_out, zero_out
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: WIDTH bits split into STAGES slices summed one per
// cycle with a registered carry. Optional saturation under PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
  parameter int WIDTH  = 32,   // must be divisible by STAGES
  parameter int STAGES = 4     // >= 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pipe_addsub_if.slave bus
);
  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;

  logic             advance;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;

  // Per-stage operands, partial result and carry; *_d are the stage inputs.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] r_d   [STAGES];
  logic             c_d   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic             c_nx  [STAGES];
`ifdef PIPE_ADDSUB_SAT_EN
  logic             s_q   [STAGES];
  logic             s_d   [STAGES];
`endif

  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] res;
  logic             ovf;

  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment so no latch can be inferred.
  always_comb begin
    advance   = !v_q[LAST] || bus.ready_in;
    slice_sum = '0;

    v_d[0] = bus.valid_in;
    a_d[0] = bus.data1_in;
    b_d[0] = bus.sub_in ? ~bus.data2_in : bus.data2_in;
    r_d[0] = '0;
    c_d[0] = bus.sub_in ? 1'b1 : bus.carry_in;
`ifdef PIPE_ADDSUB_SAT_EN
    s_d[0] = bus.sat_in;
`endif
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      r_d[k] = r_q[k-1];
      c_d[k] = c_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
      s_d[k] = s_q[k-1];
`endif
    end

    // Stage k fills slice k of the running result and produces its carry.
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_d[k][k*SW +: SW]} + {1'b0, b_d[k][k*SW +: SW]}
                + {{SW{1'b0}}, c_d[k]};
      sum_r[k]  = r_d[k];
      sum_r[k][k*SW +: SW] = slice_sum[SW-1:0];
      c_nx[k]   = slice_sum[SW];
    end

    // b_d already holds ~B for subtract, so one rule covers both operations.
    ovf = (a_d[LAST][MSB] == b_d[LAST][MSB]) && (sum_r[LAST][MSB] != a_d[LAST][MSB]);
    res = sum_r[LAST];
`ifdef PIPE_ADDSUB_SAT_EN
    if (s_d[LAST] && ovf) begin
      res = a_d[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // observed behind a valid bit, which is reset.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= sum_r[k];
        c_q[k] <= c_nx[k];
`ifdef PIPE_ADDSUB_SAT_EN
        s_q[k] <= s_d[k];
`endif
      end
    end
  end

  // Output registers load only with a real result so bubbles leave them intact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      v_q <= v_d;
      if (v_d[LAST]) begin
        data_q  <= res;
        carry_q <= c_nx[LAST];
        ovf_q   <= ovf;
        zero_q  <= (res == '0);
      end
    end
  end

  assign bus.ready_out    = advance;
  assign bus.valid_out    = v_q[LAST];
  assign bus.data_out     = data_q;
  assign bus.carry_out    = carry_q;
  assign bus.overflow_out = ovf_q;
  assign bus.zero_out     = zero_q;
endmodule
